// File: rtl/lfm_pulse_tx_pkg.sv
// ---------------------------------------------------------------------------
// lfm_pulse_tx_pkg
// Shared definitions for the LFM chirp transmitter. The default sample width,
// phase width and pulse length are kept here so the transmitter and the
// receive-side pulse-compression filter are built from the same numbers.
// Contents:
//   DEF_WIDTH / DEF_PHASE_W / DEF_PULSE_LEN : shared default sizes
//   LUT_DEPTH / LUT_AW                      : quarter-wave table geometry
//   state_t                                 : pulse sequencer states
//   lut_value()                             : elaboration-time table generator
// ---------------------------------------------------------------------------
package lfm_pulse_tx_pkg;

  localparam int DEF_WIDTH     = 12;
  localparam int DEF_PHASE_W   = 16;
  localparam int DEF_PULSE_LEN = 64;

  // Quarter wave plus the closing sample at pi/2, so LUT[256] = full scale.
  localparam int LUT_DEPTH = 257;
  localparam int LUT_AW    = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    LISTEN = 2'd2
  } state_t;

  // round(peak * sin(pi*k/512)) for k = 0..256. Evaluated only while the
  // table is elaborated; a Taylor series to x^21 is far below half an LSB
  // over [0, pi/2].
  function automatic int lut_value(input int k, input int peak);
    real x;
    real term;
    real s;
    x    = 3.14159265358979323846 * real'(k) / 512.0;
    s    = x;
    term = x;
    for (int i = 1; i <= 10; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    return $rtoi(real'(peak) * s + 0.5);
  endfunction

endpackage

// File: rtl/lfm_pulse_tx_if.sv
// ---------------------------------------------------------------------------
// lfm_pulse_tx_if
// Baseband sample stream leaving the chirp transmitter.
//   tx_I, tx_Q   : signed cosine / sine samples, zero when tx_valid is low
//   tx_valid     : sample qualifier, PULSE_LEN consecutive cycles per PRI
//   pulse_start  : strobe on the first valid sample of a pulse
//   pulse_end    : strobe on the last valid sample of a pulse
// master = the transmitter, slave = DAC / loopback consumer.
// ---------------------------------------------------------------------------
interface lfm_pulse_tx_if #(
  parameter int WIDTH = 12
);
  logic signed [WIDTH-1:0] tx_I;
  logic signed [WIDTH-1:0] tx_Q;
  logic                    tx_valid;
  logic                    pulse_start;
  logic                    pulse_end;

  modport master (
    output tx_I,
    output tx_Q,
    output tx_valid,
    output pulse_start,
    output pulse_end
  );

  modport slave (
    input tx_I,
    input tx_Q,
    input tx_valid,
    input pulse_start,
    input pulse_end
  );
endinterface

// File: rtl/lfm_pulse_tx_lut.sv
// ---------------------------------------------------------------------------
// quarter_sin_lut
// Dual-read-port quarter-wave sine ROM, LUT[k] = round(peak*sin(pi*k/512)),
// k = 0..256, with registered outputs so it maps onto block RAM.
//   clk      : clock
//   addr_a_i : read address, port A (9 bits)
//   addr_b_i : read address, port B (9 bits)
//   data_a_o : unsigned magnitude for addr_a_i, one cycle later
//   data_b_o : unsigned magnitude for addr_b_i, one cycle later
// ---------------------------------------------------------------------------
module quarter_sin_lut
  import lfm_pulse_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr_a_i,
  input  logic [LUT_AW-1:0] addr_b_i,
  output logic [WIDTH-1:0]  data_a_o,
  output logic [WIDTH-1:0]  data_b_o
);

  localparam int PEAK = (1 << (WIDTH - 1)) - 1;

  logic [WIDTH-1:0] rom [LUT_DEPTH];

  // Table contents are generated at elaboration from the package function.
  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
    assign rom[gi] = WIDTH'(lut_value(gi, PEAK));
  end

  always_ff @(posedge clk) begin
    data_a_o <= rom[addr_a_i];
    data_b_o <= rom[addr_b_i];
  end

endmodule

// File: rtl/lfm_pulse_tx.sv
// ---------------------------------------------------------------------------
// lfm_pulse_tx
// LFM chirp pulse generator. Once per PRI it emits PULSE_LEN complex samples
// from a quadratic-phase accumulator driving a quarter-wave sine table.
// Pipeline: phase register -> registered LUT read -> registered quadrant /
// sign correction, so a start sampled at edge k puts sample n out after
// edge k+2+n. Flags and busy travel through the same two stages.
//   clk    : sample clock
//   rst    : synchronous reset, active high
//   en     : continuous PRI operation while high
//   single : one-cycle request for one PRI, honoured only in IDLE
//   tx     : sample stream (tx_I, tx_Q, tx_valid, pulse_start, pulse_end)
//   busy   : sequencer not idle, aligned with the output stream
// ---------------------------------------------------------------------------
module lfm_pulse_tx
  import lfm_pulse_tx_pkg::*;
#(
  parameter int                 WIDTH      = DEF_WIDTH,
  parameter int                 PHASE_W    = DEF_PHASE_W,
  parameter int                 PULSE_LEN  = DEF_PULSE_LEN,
  parameter int                 PRI_LEN    = 1024,
  parameter logic [PHASE_W-1:0] FREQ_START = 16'hE000,
  parameter logic [PHASE_W-1:0] CHIRP_RATE = 16'h0080
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 single,
  lfm_pulse_tx_if.master       tx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(PRI_LEN);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(PRI_LEN - PULSE_LEN - 1);

  // ---------------- sequencer and phase accumulators ----------------
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] freq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      freq_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en || single) begin
            state_q <= PULSE;
            cnt_q   <= '0;
            phase_q <= '0;
            freq_q  <= FREQ_START;
          end
        end
        PULSE: begin
          phase_q <= phase_q + freq_q;
          freq_q  <= freq_q + CHIRP_RATE;
          if (cnt_q == PULSE_LAST) begin
            state_q <= LISTEN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LISTEN: begin
          if (cnt_q == LISTEN_LAST) begin
            cnt_q <= '0;
            // A single-shot run ends here unless en asks for more PRIs.
            if (en) begin
              state_q <= PULSE;
              phase_q <= '0;
              freq_q  <= FREQ_START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---------------- stage 1: table read ----------------
  logic [LUT_AW-1:0] addr_a;
  logic [LUT_AW-1:0] addr_b;
  logic [WIDTH-1:0]  mag_a;   // LUT[r]
  logic [WIDTH-1:0]  mag_b;   // LUT[256-r]

  assign addr_a = {1'b0, phase_q[PHASE_W-3 -: 8]};
  assign addr_b = LUT_AW'(LUT_DEPTH - 1) - addr_a;

  quarter_sin_lut #(
    .WIDTH(WIDTH)
  ) u_lut (
    .clk      (clk),
    .addr_a_i (addr_a),
    .addr_b_i (addr_b),
    .data_a_o (mag_a),
    .data_b_o (mag_b)
  );

  logic       vld1_q;
  logic       sop1_q;
  logic       eop1_q;
  logic       busy1_q;
  logic [1:0] quad1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      sop1_q  <= 1'b0;
      eop1_q  <= 1'b0;
      busy1_q <= 1'b0;
      quad1_q <= 2'd0;
    end else begin
      vld1_q  <= (state_q == PULSE);
      sop1_q  <= (state_q == PULSE) && (cnt_q == '0);
      eop1_q  <= (state_q == PULSE) && (cnt_q == PULSE_LAST);
      busy1_q <= (state_q != IDLE);
      quad1_q <= phase_q[PHASE_W-1 -: 2];
    end
  end

  // ---------------- stage 2: quadrant fold ----------------
  // Odd quadrants swap the cos/sin roles of the two table reads; cos is
  // negative in quadrants 1 and 2, sin in quadrants 2 and 3. Magnitudes
  // never exceed 2^(WIDTH-1)-1, so negation cannot overflow.
  logic [WIDTH-1:0] cos_mag;
  logic [WIDTH-1:0] sin_mag;
  logic             cos_neg;
  logic             sin_neg;

  always_comb begin
    cos_mag = quad1_q[0] ? mag_a : mag_b;
    sin_mag = quad1_q[0] ? mag_b : mag_a;
    cos_neg = quad1_q[1] ^ quad1_q[0];
    sin_neg = quad1_q[1];
  end

  logic signed [WIDTH-1:0] tx_i_q;
  logic signed [WIDTH-1:0] tx_q_q;
  logic                    vld2_q;
  logic                    sop2_q;
  logic                    eop2_q;
  logic                    busy2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_i_q  <= '0;
      tx_q_q  <= '0;
      vld2_q  <= 1'b0;
      sop2_q  <= 1'b0;
      eop2_q  <= 1'b0;
      busy2_q <= 1'b0;
    end else begin
      vld2_q  <= vld1_q;
      sop2_q  <= sop1_q;
      eop2_q  <= eop1_q;
      busy2_q <= busy1_q;
      if (vld1_q) begin
        tx_i_q <= cos_neg ? -$signed(cos_mag) : $signed(cos_mag);
        tx_q_q <= sin_neg ? -$signed(sin_mag) : $signed(sin_mag);
      end else begin
        tx_i_q <= '0;
        tx_q_q <= '0;
      end
    end
  end

  assign tx.tx_I        = tx_i_q;
  assign tx.tx_Q        = tx_q_q;
  assign tx.tx_valid    = vld2_q;
  assign tx.pulse_start = sop2_q;
  assign tx.pulse_end   = eop2_q;
  assign busy           = busy2_q;

endmodule

// File: tb/tb_lfm_pulse_tx.sv
// ---------------------------------------------------------------------------
// tb_lfm_pulse_tx
// Two transmitters: dut_a with default chirp parameters, dut_b with a fixed
// fs/4 tone (FREQ_START=16'h4000, CHIRP_RATE=0). Expected samples are pushed
// to per-DUT queues when a pulse is requested and popped by negedge monitors.
// ---------------------------------------------------------------------------
module tb_lfm_pulse_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, single_a = 1'b0, busy_a;
  logic en_b = 1'b0, single_b = 1'b0, busy_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lfm_pulse_tx_if #(.WIDTH(12)) a_if ();
  lfm_pulse_tx_if #(.WIDTH(12)) b_if ();

  lfm_pulse_tx dut_a (
    .clk(clk), .rst(rst), .en(en_a), .single(single_a), .tx(a_if), .busy(busy_a)
  );

  lfm_pulse_tx #(
    .FREQ_START(16'h4000), .CHIRP_RATE(16'h0000)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .single(single_b), .tx(b_if), .busy(busy_b)
  );

  typedef struct packed {
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic               sop;
    logic               eop;
  } samp_t;

  typedef struct {
    logic rst;
    logic en;
    logic single;
    logic starts;      // this vector launches a pulse: push its samples
    logic exp_busy;
    logic exp_valid;
    logic exp_start;
  } vec_t;

  samp_t qa[$];
  samp_t qb[$];
  int    starts_a[$];
  int    starts_b[$];
  samp_t ea, eb;
  int    lut[257];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden chirp for the default parameters.
  task automatic push_model_a();
    logic [15:0] ph, fr;
    int quad, r, ma, mb, ci, si;
    samp_t e;
    ph = 16'h0000;
    fr = 16'hE000;
    for (int n = 0; n < 64; n++) begin
      quad = int'(ph[15:14]);
      r    = int'(ph[13:6]);
      ma   = lut[r];
      mb   = lut[256 - r];
      case (quad)
        0:       begin ci =  mb; si =  ma; end
        1:       begin ci = -ma; si =  mb; end
        2:       begin ci = -mb; si = -ma; end
        default: begin ci =  ma; si = -mb; end
      endcase
      e.i   = ci[11:0];
      e.q   = si[11:0];
      e.sop = (n == 0);
      e.eop = (n == 63);
      qa.push_back(e);
      ph = ph + fr;
      fr = fr + 16'h0080;
    end
  endtask

  // fs/4 tone: (2047,0), (0,2047), (-2047,0), (0,-2047) repeating.
  task automatic push_tone_b();
    samp_t e;
    int pi_tab[4];
    int pq_tab[4];
    pi_tab = '{2047, 0, -2047, 0};
    pq_tab = '{0, 2047, 0, -2047};
    for (int n = 0; n < 64; n++) begin
      e.i   = 12'(pi_tab[n % 4]);
      e.q   = 12'(pq_tab[n % 4]);
      e.sop = (n == 0);
      e.eop = (n == 63);
      qb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (a_if.pulse_start) starts_a.push_back(cyc);
    if (a_if.tx_valid) begin
      if (qa.size() == 0) check("a_unexpected_valid", 64'd1, 64'd0);
      else begin
        ea = qa.pop_front();
        check("a_sample", {a_if.tx_I, a_if.tx_Q, a_if.pulse_start, a_if.pulse_end}, ea);
      end
    end else begin
      check("a_idle_zero", {a_if.tx_I, a_if.tx_Q, a_if.pulse_start, a_if.pulse_end}, 64'd0);
    end
  end

  always @(negedge clk) begin
    if (b_if.pulse_start) starts_b.push_back(cyc);
    if (b_if.tx_valid) begin
      if (qb.size() == 0) check("b_unexpected_valid", 64'd1, 64'd0);
      else begin
        eb = qb.pop_front();
        check("b_sample", {b_if.tx_I, b_if.tx_Q, b_if.pulse_start, b_if.pulse_end}, eb);
      end
    end else begin
      check("b_idle_zero", {b_if.tx_I, b_if.tx_Q, b_if.pulse_start, b_if.pulse_end}, 64'd0);
    end
  end

  task automatic wait_starts(input bit sel_b, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel_b ? starts_b.size() : starts_a.size()) >= n) return;
    end
    check(sel_b ? "b_start_timeout" : "a_start_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_fall(input bit sel_b, input int budget, output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!(sel_b ? busy_b : busy_a)) begin
        fall_cyc = cyc;
        return;
      end
    end
    check(sel_b ? "b_busy_timeout" : "a_busy_timeout", 64'd1, 64'd0);
  endtask

  vec_t vecs[10];
  int   drv, fall, rel;

  initial begin
    for (int k = 0; k < 257; k++)
      lut[k] = $rtoi(2047.0 * $sin(3.14159265358979323846 * real'(k) / 512.0) + 0.5);

    //          rst   en    sgl   strt  busy  vld   sop
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // single under reset
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // edge k
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // edge k+1
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};  // edge k+2: sample 0
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};  // single while busy

    // ---- reset state, single shot, single-while-busy ----
    for (int v = 0; v < 10; v++) begin
      @(negedge clk); #1;
      rst      = vecs[v].rst;
      en_a     = vecs[v].en;
      single_a = vecs[v].single;
      if (vecs[v].starts) push_model_a();
      @(posedge clk); #1;
      check($sformatf("vec%0d", v),
            {61'd0, busy_a, a_if.tx_valid, a_if.pulse_start},
            {61'd0, vecs[v].exp_busy, vecs[v].exp_valid, vecs[v].exp_start});
    end
    @(negedge clk); #1;
    single_a = 1'b0;
    wait_fall(1'b0, 1100, fall);
    check("single_busy_len", 64'(fall - starts_a[0]), 64'd1024);
    repeat (60) @(negedge clk);
    check("single_one_pulse", 64'(starts_a.size()), 64'd1);
    check("single_q_empty", 64'(qa.size()), 64'd0);

    // ---- continuous: three PRIs ----
    starts_a.delete();
    @(negedge clk); #1;
    en_a = 1'b1;
    drv  = cyc;
    repeat (3) push_model_a();
    wait_starts(1'b0, 3, 3200);
    @(negedge clk); #1;
    en_a = 1'b0;
    wait_fall(1'b0, 1100, fall);
    check("cont_latency", 64'(starts_a[0] - drv), 64'd3);
    check("cont_pri_1", 64'(starts_a[1] - starts_a[0]), 64'd1024);
    check("cont_pri_2", 64'(starts_a[2] - starts_a[1]), 64'd1024);
    check("cont_busy_len", 64'(fall - starts_a[2]), 64'd1024);
    check("cont_q_empty", 64'(qa.size()), 64'd0);

    // ---- en dropped at sample ~20 of the second pulse ----
    starts_a.delete();
    @(negedge clk); #1;
    en_a = 1'b1;
    repeat (2) push_model_a();
    wait_starts(1'b0, 2, 2200);
    repeat (20) @(negedge clk);
    #1;
    en_a = 1'b0;
    wait_fall(1'b0, 1100, fall);
    check("drop_busy_len", 64'(fall - starts_a[1]), 64'd1024);
    repeat (100) @(negedge clk);
    check("drop_no_third", 64'(starts_a.size()), 64'd2);
    check("drop_q_empty", 64'(qa.size()), 64'd0);

    // ---- reset at sample 30, then restart from phase 0 ----
    starts_a.delete();
    @(negedge clk); #1;
    en_a = 1'b1;
    push_model_a();
    wait_starts(1'b0, 1, 100);
    for (int i = 0; i < 100 && cyc < starts_a[0] + 30; i++) @(negedge clk);
    #1;
    rst = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    check("rst_flush", {busy_a, a_if.tx_valid, a_if.tx_I, a_if.tx_Q}, 64'd0);
    rst = 1'b0;
    rel = cyc;
    push_model_a();
    wait_starts(1'b0, 2, 100);
    check("rst_restart_latency", 64'(starts_a[1] - rel), 64'd3);
    @(negedge clk); #1;
    en_a = 1'b0;
    wait_fall(1'b0, 1100, fall);
    check("rst_q_empty", 64'(qa.size()), 64'd0);

    // ---- fixed fs/4 tone on dut_b ----
    starts_b.delete();
    @(negedge clk); #1;
    single_b = 1'b1;
    drv      = cyc;
    push_tone_b();
    @(negedge clk); #1;
    single_b = 1'b0;
    wait_starts(1'b1, 1, 100);
    wait_fall(1'b1, 1100, fall);
    check("tone_latency", 64'(starts_b[0] - drv), 64'd3);
    check("tone_busy_len", 64'(fall - starts_b[0]), 64'd1024);
    check("tone_q_empty", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfm_pulse_tx.md
Name: lfm_pulse_tx

Overview:
Transmit-side chirp (LFM) pulse generator. It produces the baseband I/Q pulse that the 64-tap pulse-compression matched filter on the receive path is designed to compress. Each PRI it emits one PULSE_LEN-sample complex chirp, synthesised by a quadratic-phase accumulator feeding a quarter-wave sine LUT. The output feeds the DAC/upconversion path and the loopback test path into the receiver.

Parameters:
WIDTH, 12, signed output sample width; full-scale LUT peak is 2^(WIDTH-1)-1 = 2047.
PHASE_W, 16, phase and frequency accumulator width (unsigned, wraps modulo 2^PHASE_W).
PULSE_LEN, 64, samples per pulse (must equal the matched-filter tap count).
PRI_LEN, 1024, cycles between successive pulse starts; PRI_LEN >= PULSE_LEN+4.
FREQ_START, 16'hE000, initial phase increment (two's-complement, i.e. -fs/8).
CHIRP_RATE, 16'h0080, per-sample increment of the phase increment.

Ports:
clk  in  1  sample clock
rst  in  1  synchronous reset, active-high
en  in  1  continuous PRI operation while high
single  in  1  one-cycle request for exactly one PRI (ignored unless IDLE)
tx_I  out  WIDTH  signed cosine sample; 0 when tx_valid=0
tx_Q  out  WIDTH  signed sine sample; 0 when tx_valid=0
tx_valid  out  1  sample valid, high for exactly PULSE_LEN consecutive cycles per PRI
pulse_start  out  1  one-cycle strobe coincident with the first valid sample
pulse_end  out  1  one-cycle strobe coincident with the last valid sample
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; accumulators 0; sample and PRI counters 0. Reset mid-pulse forces outputs to 0 on the next edge and flushes the pipeline. No partial samples follow.
- FSM IDLE -> PULSE -> LISTEN:
  - IDLE -> PULSE when en=1 or single=1 is sampled. The counter, phase=0 and freq=FREQ_START are loaded.
  - PULSE lasts PULSE_LEN cycles.
  - LISTEN lasts PRI_LEN-PULSE_LEN cycles.
  - At the end of LISTEN: go to PULSE if en=1, else IDLE.
  - A single-shot run returns to IDLE after one LISTEN regardless of single.
- en deassert mid-PULSE or mid-LISTEN: the current PRI completes in full; no truncated pulse.
- single while busy: ignored.
- Phase law, n = 0..PULSE_LEN-1:
  - phase[0]=0, freq[0]=FREQ_START.
  - phase[n+1] = phase[n] + freq[n] and freq[n+1] = freq[n] + CHIRP_RATE, both mod 2^PHASE_W.
- LUT addressing: quad = phase[PHASE_W-1:PHASE_W-2], r = phase[PHASE_W-3:PHASE_W-10] (0..255). LUT[k] = round(2047*sin(pi*k/512)), k = 0..256, so LUT[256]=2047.
- Quadrant map (cos, sin):
  - q0: (LUT[256-r], LUT[r])
  - q1: (-LUT[r], LUT[256-r])
  - q2: (-LUT[256-r], -LUT[r])
  - q3: (LUT[r], -LUT[256-r])
- Pipeline: phase register -> registered LUT read -> registered sign/quadrant correction.
- Latency: start sampled at edge k; sample n appears after edge k+2+n.
- tx_valid, pulse_start and pulse_end are delayed with the data so they stay aligned.
- Timing invariant: successive pulse_start strobes are exactly PRI_LEN cycles apart while en stays high.
- Negation is exact: LUT values never exceed 2047, so no overflow into -2048.

Decomposition:
- Shared package (radar_pkg):
  - WIDTH, PULSE_LEN and PHASE_W defaults, so the transmitter and the compression filter cannot diverge.
  - FSM state enum {IDLE, PULSE, LISTEN}.
  - LUT_DEPTH=257.
- Sub-module quarter_sin_lut:
  - 9-bit address, WIDTH-bit unsigned registered output.
  - Two read ports, for the r and 256-r addresses.
  - Contents from a generated init file.

Test Plan:
1. rst=1 for 3 cycles, en=0 -> all outputs 0, busy=0; single pulse on rst release -> still IDLE until the next single.
2. FREQ_START=16'h4000, CHIRP_RATE=0, single=1 -> first 4 samples (2047,0), (0,2047), (-2047,0), (0,-2047) repeating; tx_valid high 64 cycles; pulse_start on sample 0; pulse_end on sample 63.
3. Defaults, en held high for 3 PRIs -> pulse_start at cycles k+2, k+1026, k+2050; 64 valid samples each; bit-exact match against the golden model.
4. en dropped at sample 20 of the 2nd pulse -> that pulse delivers all 64 samples; busy falls exactly 1024 cycles after its pulse_start; no 3rd pulse.
5. rst asserted at sample 30 -> tx_valid=0, tx_I=tx_Q=0 next cycle; with en=1, a fresh pulse restarts from phase 0 after rst release.
6. Loopback through the pulse-compression filter -> the |pc|^2 peak occurs exactly once per PRI, at the constant offset from pulse_end; peak sidelobe ratio >= 13 dB.
